// File: rtl/serail_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the serial slave.
// Signal suffixes are from the arbiter's point of view.
interface serail_arbiter_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
);
  logic              req0_ce_i, req0_we_i;
  logic [ADDR_W-1:0] req0_addr_i;
  logic [DATA_W-1:0] req0_data_i, req0_data_o;
  logic              req0_ack_o, req0_err_o;
  logic              req1_ce_i, req1_we_i;
  logic [ADDR_W-1:0] req1_addr_i;
  logic [DATA_W-1:0] req1_data_i, req1_data_o;
  logic              req1_ack_o, req1_err_o;
  logic              serail_ce_o, serail_we_o;
  logic [ADDR_W-1:0] serail_addr_o;
  logic [DATA_W-1:0] serail_data_o, serail_data_i;
  logic              serail_ready_i;
  logic              busy_o, grant_o;

  // arbiter side
  modport slave (
    input  req0_ce_i, req0_we_i, req0_addr_i, req0_data_i,
    input  req1_ce_i, req1_we_i, req1_addr_i, req1_data_i,
    input  serail_data_i, serail_ready_i,
    output req0_data_o, req0_ack_o, req0_err_o,
    output req1_data_o, req1_ack_o, req1_err_o,
    output serail_ce_o, serail_we_o, serail_addr_o, serail_data_o,
    output busy_o, grant_o
  );

  // environment side: requesters plus the serial device
  modport master (
    output req0_ce_i, req0_we_i, req0_addr_i, req0_data_i,
    output req1_ce_i, req1_we_i, req1_addr_i, req1_data_i,
    output serail_data_i, serail_ready_i,
    input  req0_data_o, req0_ack_o, req0_err_o,
    input  req1_data_o, req1_ack_o, req1_err_o,
    input  serail_ce_o, serail_we_o, serail_addr_o, serail_data_o,
    input  busy_o, grant_o
  );
endinterface

// File: rtl/serail_arbiter.sv
// Two-port round-robin arbiter / access sequencer for the serial slave.
// IDLE grants, ACCESS waits for ready or timeout, DONE acks and forces
// a ce-low gap of at least two cycles before the next access.

// Per-port response registers: read data, ack pulse, error flag.
module serail_arbiter_port #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              done_i,   // this port's access finishes now
  input  logic              rd_i,
  input  logic              err_i,
  input  logic              clr_i,    // leaving DONE
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] data_o,
  output logic              ack_o,
  output logic              err_o
);
  logic [DATA_W-1:0] data_q;
  logic              ack_q, err_q;

  // ack/err live for the DONE cycle only; read data is held until replaced
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q <= '0;
      ack_q  <= 1'b0;
      err_q  <= 1'b0;
    end else if (done_i) begin
      ack_q <= 1'b1;
      err_q <= err_i;
      if (rd_i) data_q <= err_i ? '0 : rdata_i;
    end else if (clr_i) begin
      ack_q <= 1'b0;
      err_q <= 1'b0;
    end
  end

  assign data_o = data_q;
  assign ack_o  = ack_q;
  assign err_o  = err_q;
endmodule

module serail_arbiter #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 255
) (
  input logic             clk,
  input logic             rst,
  serail_arbiter_if.slave bus
);
  localparam int NPORT = 2;

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t            state_q, state_d;
  logic              ce_q, ce_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              gnt_q, gnt_d, last_q, last_d, busy_q, busy_d;
  logic              fin, fin_err, clr, sel;

  logic [NPORT-1:0]             req_ce, req_we, rsp_ack, rsp_err;
  logic [NPORT-1:0][ADDR_W-1:0] req_addr;
  logic [NPORT-1:0][DATA_W-1:0] req_wdata, rsp_data;

  assign req_ce    = {bus.req1_ce_i,   bus.req0_ce_i};
  assign req_we    = {bus.req1_we_i,   bus.req0_we_i};
  assign req_addr  = {bus.req1_addr_i, bus.req0_addr_i};
  assign req_wdata = {bus.req1_data_i, bus.req0_data_i};

  // next state: grant in IDLE, ready/timeout in ACCESS, ack in DONE
  always_comb begin
    state_d = state_q;
    ce_d    = ce_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    busy_d  = busy_q;
    fin     = 1'b0;
    fin_err = 1'b0;
    clr     = 1'b0;
    // on a tie the port that did not win last time goes first
    sel     = (&req_ce) ? ~last_q : req_ce[1];
    unique case (state_q)
      IDLE: begin
        if (|req_ce) begin
          gnt_d   = sel;
          ce_d    = 1'b1;
          we_d    = req_we[sel];
          addr_d  = req_addr[sel];
          wdata_d = req_wdata[sel];
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        cnt_d = cnt_q + 8'd1;
        // ready wins over a timeout landing in the same cycle
        if (bus.serail_ready_i) begin
          fin = 1'b1;
        end else if (cnt_q == 8'(TIMEOUT)) begin
          fin     = 1'b1;
          fin_err = 1'b1;
        end
        if (fin) begin
          ce_d    = 1'b0;
          we_d    = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        clr     = 1'b1;
        last_d  = gnt_q;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // state and slave-side registers; reset drops ce to the slave at once
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ce_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
      gnt_q   <= 1'b0;
      last_q  <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ce_q    <= ce_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      busy_q  <= busy_d;
    end
  end

  for (genvar p = 0; p < NPORT; p++) begin : g_port
    serail_arbiter_port #(.DATA_W(DATA_W)) u_port (
      .clk    (clk),
      .rst    (rst),
      .done_i (fin && (gnt_q == 1'(p))),
      .rd_i   (!we_q),
      .err_i  (fin_err),
      .clr_i  (clr),
      .rdata_i(bus.serail_data_i),
      .data_o (rsp_data[p]),
      .ack_o  (rsp_ack[p]),
      .err_o  (rsp_err[p])
    );
  end

  assign bus.req0_data_o   = rsp_data[0];
  assign bus.req0_ack_o    = rsp_ack[0];
  assign bus.req0_err_o    = rsp_err[0];
  assign bus.req1_data_o   = rsp_data[1];
  assign bus.req1_ack_o    = rsp_ack[1];
  assign bus.req1_err_o    = rsp_err[1];
  assign bus.serail_ce_o   = ce_q;
  assign bus.serail_we_o   = we_q;
  assign bus.serail_addr_o = addr_q;
  assign bus.serail_data_o = wdata_q;
  assign bus.busy_o        = busy_q;
  assign bus.grant_o       = gnt_q;
endmodule
